bsg_cache_nb_src_arbiter: RTL and testbench

Shares one request port of the non-blocking cache (`bsg_cache_nb`) among `num_req_p` requesters. Each cycle it picks one requester round-robin, stamps the packet with a free `src_id` tag from a pool, and records which requester owns that tag. Cache responses come back out of order. They are routed to the owning requester by `src_id`, and the tag is released on the response handshake. It sits between core/DMA request ports and the cache, replacing fixed per-source ID assignment.

---
 rtl/bsg_cache_nb_src_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_bsg_cache_nb_src_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cache_nb_src_arbiter.sv
// bsg_cache_nb_src_arbiter
//
// Shares one request port of the non-blocking cache among num_req_p
// requesters. Each cycle it picks one eligible requester round-robin and
// stamps its packet with a free src_id tag taken from a pool. It also
// records which requester owns that tag. Out-of-order cache responses are
// steered back to the owning requester by tag. The tag returns to the pool
// on the response handshake.
//
// Packet layout (MSB..LSB): opcode[5:0], addr, data, mask[word/8], src_id.
// The src_id field occupies the low src_id_width_p bits. This arbiter
// overwrites that field with the allocated tag.
//
// Ports
//   clk_i, reset_n_i         : clock, asynchronous active-low reset
//   req_v_i/req_pkt_i        : per-requester request valid and packet
//   req_yumi_o               : per-requester request consumed
//   cache_pkt_o/cache_v_o    : granted, re-tagged request toward the cache
//   cache_yumi_i             : cache consumed the request
//   cache_src_id_i           : response tag, MSB=1 marks a tagged completion
//   cache_data_i/cache_v_i   : response data and valid from the cache
//   cache_yumi_o             : response consumed
//   resp_data_o/resp_v_o     : shared response data, one-hot response valid
//   resp_yumi_i              : requester consumed its response
//   outstanding_o            : number of tags currently allocated
//   error_o                  : sticky error, response to an unallocated tag
module bsg_cache_nb_src_arbiter #(
   parameter int num_req_p      = 4,
   parameter int word_width_p   = 32,
   parameter int addr_width_p   = 32,
   parameter int src_id_width_p = 3,
   parameter int max_out_p      = 4,
   localparam int pkt_width_lp  = 6 + addr_width_p + word_width_p
                                  + (word_width_p / 8) + src_id_width_p
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,

   input  logic [num_req_p-1:0]              req_v_i,
   input  logic [num_req_p*pkt_width_lp-1:0] req_pkt_i,
   output logic [num_req_p-1:0]              req_yumi_o,

   output logic [pkt_width_lp-1:0]           cache_pkt_o,
   output logic                              cache_v_o,
   input  logic                              cache_yumi_i,

   input  logic [src_id_width_p:0]           cache_src_id_i,
   input  logic [word_width_p-1:0]           cache_data_i,
   input  logic                              cache_v_i,
   output logic                              cache_yumi_o,

   output logic [word_width_p-1:0]           resp_data_o,
   output logic [num_req_p-1:0]              resp_v_o,
   input  logic [num_req_p-1:0]              resp_yumi_i,

   output logic [src_id_width_p:0]           outstanding_o,
   output logic                              error_o
);

   localparam int tags_lp  = 1 << src_id_width_p;
   localparam int req_w_lp = $clog2(num_req_p);
   localparam int cnt_w_lp = $clog2(max_out_p + 1);
   localparam int os_w_lp  = src_id_width_p + 1;

   logic [tags_lp-1:0]  r_free;
   logic [req_w_lp-1:0] r_owner [tags_lp];
   logic [cnt_w_lp-1:0] r_cnt   [num_req_p];
   logic [req_w_lp-1:0] r_rr_ptr;
   logic                r_error;
   logic [os_w_lp-1:0]  r_outstanding;

   logic [num_req_p-1:0]      w_elig;
   logic                      w_any_elig;
   logic [req_w_lp-1:0]       w_grant;
   logic [req_w_lp-1:0]       w_rr_next;
   logic                      w_any_free;
   logic [src_id_width_p-1:0] w_tag;
   logic                      w_req_fire;

   logic                      w_rsp_tagged;
   logic [src_id_width_p-1:0] w_rsp_tag;
   logic [req_w_lp-1:0]       w_rsp_owner;
   logic                      w_rsp_good;
   logic                      w_rsp_fire;
   logic                      w_rsp_err;
   logic                      w_rsp_drop;

   logic [tags_lp-1:0]   w_free_next;
   logic [os_w_lp-1:0]   w_os_next;
   logic [num_req_p-1:0] w_cnt_inc;
   logic [num_req_p-1:0] w_cnt_dec;

   // A requester can compete only while it is below its outstanding limit.
   always_comb begin
      for (int i = 0; i < num_req_p; i++) begin
         w_elig[i] = req_v_i[i] && (r_cnt[i] < cnt_w_lp'(max_out_p));
      end
   end

   // Allocation candidate is the lowest free tag in the registered pool, so
   // a tag released this cycle is not handed out again until next cycle.
   always_comb begin
      w_any_free = |r_free;
      w_tag      = '0;
      for (int t = tags_lp - 1; t >= 0; t--) begin
         if (r_free[t]) w_tag = src_id_width_p'(t);
      end
   end

   // Round-robin search that starts at r_rr_ptr and wraps modulo num_req_p.
   always_comb begin
      int idx;
      w_any_elig = 1'b0;
      w_grant    = '0;
      idx        = 0;
      for (int k = 0; k < num_req_p; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= num_req_p) idx = idx - num_req_p;
         if (!w_any_elig && w_elig[idx]) begin
            w_any_elig = 1'b1;
            w_grant    = req_w_lp'(idx);
         end
      end
      w_rr_next = (w_grant == req_w_lp'(num_req_p - 1)) ? '0 : w_grant + 1'b1;
   end

   // Request path: the selected packet passes straight through with a new tag.
   // The reset term holds the outputs low while reset_n_i is asserted.
   always_comb begin
      cache_v_o   = reset_n_i & w_any_elig & w_any_free;
      w_req_fire  = cache_v_o & cache_yumi_i;
      req_yumi_o  = w_req_fire ? (num_req_p'(1) << w_grant) : '0;
      cache_pkt_o = {req_pkt_i[w_grant*pkt_width_lp + src_id_width_p
                               +: (pkt_width_lp - src_id_width_p)], w_tag};
   end

   // Response path. A tagged response to an owned tag goes to its owner.
   // A response to a free tag is consumed and flagged as an error.
   // An untagged response is consumed and dropped.
   always_comb begin
      w_rsp_tagged = cache_src_id_i[src_id_width_p];
      w_rsp_tag    = cache_src_id_i[src_id_width_p-1:0];
      w_rsp_owner  = r_owner[w_rsp_tag];
      w_rsp_good   = reset_n_i & cache_v_i & w_rsp_tagged & ~r_free[w_rsp_tag];
      w_rsp_err    = reset_n_i & cache_v_i & w_rsp_tagged &  r_free[w_rsp_tag];
      w_rsp_drop   = reset_n_i & cache_v_i & ~w_rsp_tagged;
      w_rsp_fire   = w_rsp_good & resp_yumi_i[w_rsp_owner];
      resp_v_o     = w_rsp_good ? (num_req_p'(1) << w_rsp_owner) : '0;
      resp_data_o  = cache_data_i;
      cache_yumi_o = w_rsp_fire | w_rsp_err | w_rsp_drop;
   end

   // The allocated tag is always free and the released tag is always owned,
   // so both updates can safely be applied in the same cycle.
   always_comb begin
      w_free_next = r_free;
      if (w_req_fire) w_free_next[w_tag]     = 1'b0;
      if (w_rsp_fire) w_free_next[w_rsp_tag] = 1'b1;
      w_os_next = '0;
      for (int t = 0; t < tags_lp; t++) begin
         w_os_next = w_os_next + os_w_lp'(!w_free_next[t]);
      end
      for (int i = 0; i < num_req_p; i++) begin
         w_cnt_inc[i] = w_req_fire && (w_grant == req_w_lp'(i));
         w_cnt_dec[i] = w_rsp_fire && (w_rsp_owner == req_w_lp'(i));
      end
   end

   // Pool, ownership, per-requester counts, round-robin pointer and status.
   // The counts cannot wrap: an increment needs cnt below the limit, and a
   // decrement needs an owned tag.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_free        <= '1;
         r_rr_ptr      <= '0;
         r_error       <= 1'b0;
         r_outstanding <= '0;
         for (int t = 0; t < tags_lp; t++) r_owner[t] <= '0;
         for (int i = 0; i < num_req_p; i++) r_cnt[i] <= '0;
      end else begin
         r_free        <= w_free_next;
         r_outstanding <= w_os_next;
         if (w_req_fire) begin
            r_owner[w_tag] <= w_grant;
            r_rr_ptr       <= w_rr_next;
         end
         if (w_rsp_err) r_error <= 1'b1;
         for (int i = 0; i < num_req_p; i++) begin
            if (w_cnt_inc[i] && !w_cnt_dec[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
            else if (w_cnt_dec[i] && !w_cnt_inc[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
         end
      end
   end

   assign outstanding_o = r_outstanding;
   assign error_o       = r_error;

endmodule

// File: tb/tb_bsg_cache_nb_src_arbiter.sv
// Testbench for bsg_cache_nb_src_arbiter. The configuration is four
// requesters, 8 tags and at most two outstanding requests per requester.
module tb_bsg_cache_nb_src_arbiter;

   localparam int NR = 4;
   localparam int WW = 32;
   localparam int AW = 16;
   localparam int SW = 3;
   localparam int MO = 2;
   localparam int PW = 6 + AW + WW + WW / 8 + SW;

   logic              clk_i;
   logic              reset_n_i;
   logic [NR-1:0]     req_v_i;
   logic [NR*PW-1:0]  req_pkt_i;
   logic [NR-1:0]     req_yumi_o;
   logic [PW-1:0]     cache_pkt_o;
   logic              cache_v_o;
   logic              cache_yumi_i;
   logic [SW:0]       cache_src_id_i;
   logic [WW-1:0]     cache_data_i;
   logic              cache_v_i;
   logic              cache_yumi_o;
   logic [WW-1:0]     resp_data_o;
   logic [NR-1:0]     resp_v_o;
   logic [NR-1:0]     resp_yumi_i;
   logic [SW:0]       outstanding_o;
   logic              error_o;

   int checks   = 0;
   int failures = 0;

   bsg_cache_nb_src_arbiter #(
      .num_req_p(NR), .word_width_p(WW), .addr_width_p(AW),
      .src_id_width_p(SW), .max_out_p(MO)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .req_v_i(req_v_i), .req_pkt_i(req_pkt_i), .req_yumi_o(req_yumi_o),
      .cache_pkt_o(cache_pkt_o), .cache_v_o(cache_v_o), .cache_yumi_i(cache_yumi_i),
      .cache_src_id_i(cache_src_id_i), .cache_data_i(cache_data_i),
      .cache_v_i(cache_v_i), .cache_yumi_o(cache_yumi_o),
      .resp_data_o(resp_data_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
      .outstanding_o(outstanding_o), .error_o(error_o)
   );

   // Free-running clock, posedge at 5, 15, 25, ...
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          rst;
      logic [3:0]  rv;
      logic        cy;
      logic        rspv;
      logic [3:0]  rid;
      logic [31:0] rdat;
      logic [3:0]  ry;
      logic        ecv;
      int          eg;
      logic [2:0]  etag;
      logic [3:0]  erv;
      logic        ecy;
      logic [3:0]  eos;
      logic        eerr;
   } vec_t;

   vec_t vecs[$];

   // Distinct packet per requester; the incoming src_id field is all ones.
   function automatic logic [PW-1:0] mkpkt(int i);
      return {6'(i + 1), 16'(16'h1000 + 16 * i), 32'(32'hA5A5_0000 + i), 4'hF, 3'b111};
   endfunction

   function automatic logic [PW-1:0] exppkt(int g, logic [2:0] tag);
      logic [PW-1:0] p;
      p = mkpkt(g);
      return {p[PW-1:SW], tag};
   endfunction

   function automatic vec_t mk(bit rst, logic [3:0] rv, logic cy, logic rspv,
                               logic [3:0] rid, logic [31:0] rdat, logic [3:0] ry,
                               logic ecv, int eg, logic [2:0] etag, logic [3:0] erv,
                               logic ecy, logic [3:0] eos, logic eerr);
      vec_t v;
      v.rst = rst; v.rv = rv; v.cy = cy; v.rspv = rspv; v.rid = rid; v.rdat = rdat;
      v.ry = ry; v.ecv = ecv; v.eg = eg; v.etag = etag; v.erv = erv; v.ecy = ecy;
      v.eos = eos; v.eerr = eerr;
      return v;
   endfunction

   task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(vec_t v);
      req_v_i        = v.rv;
      cache_yumi_i   = v.cy;
      cache_v_i      = v.rspv;
      cache_src_id_i = v.rid;
      cache_data_i   = v.rdat;
      resp_yumi_i    = v.ry;
   endtask

   task automatic idleInputs();
      req_v_i = '0; cache_yumi_i = 1'b0; cache_v_i = 1'b0;
      cache_src_id_i = '0; cache_data_i = '0; resp_yumi_i = '0;
   endtask

   initial begin
      vec_t v;
      logic [NR-1:0] eyumi;

      for (int i = 0; i < NR; i++) req_pkt_i[i*PW +: PW] = mkpkt(i);

      // Fairness: all valid, cache always yumis, tags 0..7 in grant order
      // 0,1,2,3,0,1,2,3, then stall. Tag 2 is freed and reallocated.
      vecs.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 4'h0, 1, 1, 1, 4'h0, 0, 1, 0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 4'h0, 1, 2, 2, 4'h0, 0, 2, 0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 4'h0, 1, 3, 3, 4'h0, 0, 3, 0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 4'h0, 1, 0, 4, 4'h0, 0, 4, 0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 4'h0, 1, 1, 5, 4'h0, 0, 5, 0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 4'h0, 1, 2, 6, 4'h0, 0, 6, 0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 4'h0, 1, 3, 7, 4'h0, 0, 7, 0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 8, 0));
      vecs.push_back(mk(0, 4'hF, 1, 1, 4'hA, 32'hD0D0_0002, 4'hF, 0, 0, 0, 4'b0100, 1, 8, 0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 4'h0, 1, 2, 2, 4'h0, 0, 7, 0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 8, 0));
      // Back-pressure on tag 5 (owner 1) for 3 cycles, then accepted.
      vecs.push_back(mk(0, 4'hF, 1, 1, 4'hD, 32'hBEEF_0005, 4'h0, 0, 0, 0, 4'b0010, 0, 8, 0));
      vecs.push_back(mk(0, 4'hF, 1, 1, 4'hD, 32'hBEEF_0005, 4'h0, 0, 0, 0, 4'b0010, 0, 8, 0));
      vecs.push_back(mk(0, 4'hF, 1, 1, 4'hD, 32'hBEEF_0005, 4'h0, 0, 0, 0, 4'b0010, 0, 8, 0));
      vecs.push_back(mk(0, 4'hF, 1, 1, 4'hD, 32'hBEEF_0005, 4'b0010, 0, 0, 0, 4'b0010, 1, 8, 0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 4'h0, 1, 1, 5, 4'h0, 0, 7, 0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 8, 0));

      // Per-requester limit: only requester 1, two grants, then it stalls
      // while requester 0 is still grantable.
      vecs.push_back(mk(1, 4'b0010, 1, 0, 4'h0, 0, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b0010, 1, 0, 4'h0, 0, 4'h0, 1, 1, 1, 4'h0, 0, 1, 0));
      vecs.push_back(mk(0, 4'b0010, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 2, 0));
      vecs.push_back(mk(0, 4'b0011, 1, 0, 4'h0, 0, 4'h0, 1, 0, 2, 4'h0, 0, 2, 0));

      // Error on unallocated tag 6 (sticky), then untagged response dropped.
      vecs.push_back(mk(1, 4'h0, 0, 1, 4'hE, 32'h1234, 4'hF, 0, 0, 0, 4'h0, 1, 0, 0));
      vecs.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1));
      vecs.push_back(mk(0, 4'h0, 0, 1, 4'h1, 32'h55, 4'hF, 0, 0, 0, 4'h0, 1, 0, 1));
      vecs.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1));

      // Out-of-order: build t0:r0 t1:r1 t2:r3 t3:r1 t4:r3 t5:r2, free 1,2,4,
      // then answer 5,0,3 while outstanding falls 3 -> 0.
      vecs.push_back(mk(1, 4'b0001, 1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b0010, 1, 0, 4'h0, 0, 4'h0, 1, 1, 1, 4'h0, 0, 1, 0));
      vecs.push_back(mk(0, 4'b1000, 1, 0, 4'h0, 0, 4'h0, 1, 3, 2, 4'h0, 0, 2, 0));
      vecs.push_back(mk(0, 4'b0010, 1, 0, 4'h0, 0, 4'h0, 1, 1, 3, 4'h0, 0, 3, 0));
      vecs.push_back(mk(0, 4'b1000, 1, 0, 4'h0, 0, 4'h0, 1, 3, 4, 4'h0, 0, 4, 0));
      vecs.push_back(mk(0, 4'b0100, 1, 0, 4'h0, 0, 4'h0, 1, 2, 5, 4'h0, 0, 5, 0));
      vecs.push_back(mk(0, 4'h0, 0, 1, 4'h9, 32'h1111_0001, 4'hF, 0, 0, 0, 4'b0010, 1, 6, 0));
      vecs.push_back(mk(0, 4'h0, 0, 1, 4'hA, 32'h1111_0002, 4'hF, 0, 0, 0, 4'b1000, 1, 5, 0));
      vecs.push_back(mk(0, 4'h0, 0, 1, 4'hC, 32'h1111_0004, 4'hF, 0, 0, 0, 4'b1000, 1, 4, 0));
      vecs.push_back(mk(0, 4'h0, 0, 1, 4'hD, 32'h2222_0005, 4'hF, 0, 0, 0, 4'b0100, 1, 3, 0));
      vecs.push_back(mk(0, 4'h0, 0, 1, 4'h8, 32'h2222_0000, 4'hF, 0, 0, 0, 4'b0001, 1, 2, 0));
      vecs.push_back(mk(0, 4'h0, 0, 1, 4'hB, 32'h2222_0003, 4'hF, 0, 0, 0, 4'b0010, 1, 1, 0));
      vecs.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0));

      // Reset state: outputs stay quiet even with live inputs.
      reset_n_i      = 1'b0;
      req_v_i        = 4'hF;
      cache_yumi_i   = 1'b1;
      cache_v_i      = 1'b1;
      cache_src_id_i = 4'h8;
      cache_data_i   = 32'hCAFE;
      resp_yumi_i    = 4'hF;
      #3;
      checkOutput("rst_cache_v", 64'(cache_v_o), 64'h0);
      checkOutput("rst_req_yumi", 64'(req_yumi_o), 64'h0);
      checkOutput("rst_resp_v", 64'(resp_v_o), 64'h0);
      checkOutput("rst_cache_yumi", 64'(cache_yumi_o), 64'h0);
      checkOutput("rst_outstanding", 64'(outstanding_o), 64'h0);
      checkOutput("rst_error", 64'(error_o), 64'h0);
      idleInputs();
      @(negedge clk_i);
      reset_n_i = 1'b1;

      for (int n = 0; n < vecs.size(); n++) begin
         v = vecs[n];
         if (v.rst) begin
            reset_n_i = 1'b0;
            idleInputs();
            @(negedge clk_i);
            reset_n_i = 1'b1;
         end
         applyStimulus(v);
         #1;
         eyumi = (v.ecv && v.cy) ? (NR'(1) << v.eg) : '0;
         checkOutput($sformatf("v%0d_cache_v", n), 64'(cache_v_o), 64'(v.ecv));
         checkOutput($sformatf("v%0d_req_yumi", n), 64'(req_yumi_o), 64'(eyumi));
         if (v.ecv)
            checkOutput($sformatf("v%0d_cache_pkt", n), 64'(cache_pkt_o), 64'(exppkt(v.eg, v.etag)));
         checkOutput($sformatf("v%0d_resp_v", n), 64'(resp_v_o), 64'(v.erv));
         if (v.erv != 0)
            checkOutput($sformatf("v%0d_resp_data", n), 64'(resp_data_o), 64'(v.rdat));
         checkOutput($sformatf("v%0d_cache_yumi", n), 64'(cache_yumi_o), 64'(v.ecy));
         checkOutput($sformatf("v%0d_outstanding", n), 64'(outstanding_o), 64'(v.eos));
         checkOutput($sformatf("v%0d_error", n), 64'(error_o), 64'(v.eerr));
         @(negedge clk_i);
      end

      // Asynchronous reset mid-stream. Two grants go out (requester 3 tag 0,
      // then requester 0 tag 1), then reset drops between clock edges.
      idleInputs();
      req_v_i      = 4'hF;
      cache_yumi_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      #1;
      checkOutput("ar_pre_outstanding", 64'(outstanding_o), 64'h2);
      #2;
      cache_v_i      = 1'b1;
      cache_src_id_i = 4'h9;
      resp_yumi_i    = 4'hF;
      reset_n_i      = 1'b0;
      #1;
      checkOutput("ar_cache_v", 64'(cache_v_o), 64'h0);
      checkOutput("ar_req_yumi", 64'(req_yumi_o), 64'h0);
      checkOutput("ar_resp_v", 64'(resp_v_o), 64'h0);
      checkOutput("ar_cache_yumi", 64'(cache_yumi_o), 64'h0);
      checkOutput("ar_outstanding", 64'(outstanding_o), 64'h0);
      checkOutput("ar_error", 64'(error_o), 64'h0);
      @(negedge clk_i);
      cache_v_i   = 1'b0;
      resp_yumi_i = '0;
      reset_n_i   = 1'b1;
      #1;
      checkOutput("ar_post_cache_v", 64'(cache_v_o), 64'h1);
      checkOutput("ar_post_req_yumi", 64'(req_yumi_o), 64'h1);
      checkOutput("ar_post_pkt", 64'(cache_pkt_o), 64'(exppkt(0, 3'd0)));
      @(negedge clk_i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
